// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle adder.
// Holds the controller state encoding and the slice-index width rule.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for N slices; never below one bit so N == 1 still elaborates.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Request/result bundle between a controller (master) and the adder (slave).
interface multicycle_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/adder_slice.sv
// CHUNK-wide combinational full adder; the adder reuses it once per cycle.
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit add/subtract computed CHUNK bits per clock through one slice adder,
// with the inter-slice carry held in a register and a start/busy/done handshake.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_adder_if.slave bus
);
  import adder_pkg::*;

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  generate
    if (WIDTH <= 0 || CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $fatal(1, "multicycle_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_c;
  logic             accept;
  logic             last_slice;

  assign sl_a = opa_q[int'(idx_q)*CHUNK +: CHUNK];
  assign sl_b = opb_q[int'(idx_q)*CHUNK +: CHUNK];

  adder_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_c)
  );

  assign accept     = bus.start && (state_q == IDLE || state_q == DONE);
  assign last_slice = (idx_q == LAST);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
      opa_d   = bus.a;
      opb_d   = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub;
      idx_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == RUN) begin
      sum_d[int'(idx_q)*CHUNK +: CHUNK] = sl_s;
      carry_d = sl_c;
      idx_d   = last_slice ? '0 : idx_q + 1'b1;
      if (last_slice) begin
        cout_d = sl_c;
        ovf_d  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sl_s[CHUNK-1] != opa_q[WIDTH-1]);
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // all registers sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder in 32/8, 8/8 and 4/1 configurations,
// with hand-computed results and an exhaustive 4-bit arithmetic model.
module tb_multicycle_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_adder_if #(.WIDTH(32)) m32 ();
  multicycle_adder_if #(.WIDTH(8))  m8  ();
  multicycle_adder_if #(.WIDTH(4))  m4  ();

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst(rst), .bus(m32));
  multicycle_adder #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(m8));
  multicycle_adder #(.WIDTH(4),  .CHUNK(1)) dut4  (.clk(clk), .rst(rst), .bus(m4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done (bounded); n = cycles waited, nbusy = busy cycles seen.
  task automatic wait_done32(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (m32.done !== 1'b1 && n < 40) begin
      if (m32.busy === 1'b1) nbusy++;
      tick();
      n++;
    end
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] esum, input logic ec, input logic eo);
    int n, nb;
    m32.start = 1'b1; m32.a = a; m32.b = b; m32.sub = s;
    tick();
    // Scramble the operand inputs; they must not affect the running operation.
    m32.start = 1'b0; m32.a = 32'hDEAD_BEEF; m32.b = 32'h1234_5678; m32.sub = ~s;
    wait_done32(n, nb);
    check({tag, "_done"}, m32.done, 1);
    check({tag, "_busy_cycles"}, nb, 4);
    check({tag, "_busy_with_done"}, m32.busy, 0);
    check({tag, "_sum"}, m32.sum, esum);
    check({tag, "_cout"}, m32.cout, ec);
    check({tag, "_ovf"}, m32.overflow, eo);
    tick();
    check({tag, "_done_pulse"}, m32.done, 0);
    check({tag, "_sum_held"}, m32.sum, esum);
  endtask

  initial begin
    int n, nb, seen;
    int sa, sb, res, esum, ec, eo;

    m32.start = 0; m32.sub = 0; m32.a = '0; m32.b = '0;
    m8.start  = 0; m8.sub  = 0; m8.a  = '0; m8.b  = '0;
    m4.start  = 0; m4.sub  = 0; m4.a  = '0; m4.b  = '0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", m32.busy, 0);
    check("rst_done", m32.done, 0);
    check("rst_sum", m32.sum, 0);
    check("rst_cout", m32.cout, 0);
    check("rst_ovf", m32.overflow, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", m32.busy, 0);

    op32("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    op32("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op32("sub_borrow", 32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op32("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Reset asserted on the second RUN cycle aborts with no done pulse
    m32.start = 1'b1; m32.a = 32'h0123_4567; m32.b = 32'h0101_0101; m32.sub = 1'b0;
    tick();
    m32.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", m32.busy, 0);
    check("abort_done", m32.done, 0);
    check("abort_sum", m32.sum, 0);
    check("abort_cout", m32.cout, 0);
    check("abort_ovf", m32.overflow, 0);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (m32.done === 1'b1 || m32.busy === 1'b1) seen = 1;
    end
    check("abort_no_done", seen, 0);

    // Start during RUN is ignored
    m32.start = 1'b1; m32.a = 32'd1; m32.b = 32'd2; m32.sub = 1'b0;
    tick();
    m32.start = 1'b0;
    tick();
    m32.start = 1'b1; m32.a = 32'd100; m32.b = 32'd100;
    tick();
    m32.start = 1'b0;
    wait_done32(n, nb);
    check("ign_done", m32.done, 1);
    check("ign_busy_left", nb, 2);
    check("ign_sum", m32.sum, 32'd3);

    // Back-to-back start in the DONE cycle
    m32.start = 1'b1; m32.a = 32'd10; m32.b = 32'd20;
    tick();
    m32.start = 1'b0;
    check("b2b_busy", m32.busy, 1);
    check("b2b_done", m32.done, 0);
    check("b2b_sum_cleared", m32.sum, 0);
    wait_done32(n, nb);
    check("b2b_done_after", m32.done, 1);
    check("b2b_busy_cycles", nb, 4);
    check("b2b_sum", m32.sum, 32'd30);
    tick();
    check("b2b_done_pulse", m32.done, 0);

    // Single-slice configuration
    m8.start = 1'b1; m8.a = 8'h80; m8.b = 8'h80; m8.sub = 1'b0;
    tick();
    m8.start = 1'b0;
    check("n1_busy", m8.busy, 1);
    n = 0;
    while (m8.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("n1_latency", n, 1);
    check("n1_sum", m8.sum, 8'h00);
    check("n1_cout", m8.cout, 1);
    check("n1_ovf", m8.overflow, 1);

    // Exhaustive 4-bit, 1-bit slices, against signed/unsigned arithmetic
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          m4.start = 1'b1; m4.a = 4'(a); m4.b = 4'(b); m4.sub = 1'(s);
          tick();
          m4.start = 1'b0;
          n = 0;
          while (m4.done !== 1'b1 && n < 20) begin
            tick();
            n++;
          end
          sa   = (a > 7) ? a - 16 : a;
          sb   = (b > 7) ? b - 16 : b;
          res  = (s == 1) ? sa - sb : sa + sb;
          eo   = (res > 7 || res < -8) ? 1 : 0;
          ec   = (s == 1) ? ((a >= b) ? 1 : 0) : ((a + b > 15) ? 1 : 0);
          esum = ((s == 1) ? (a - b) : (a + b)) & 15;
          check($sformatf("w4_s%0d_a%0d_b%0d_lat", s, a, b), n, 4);
          check($sformatf("w4_s%0d_a%0d_b%0d_sum", s, a, b), m4.sum, esum);
          check($sformatf("w4_s%0d_a%0d_b%0d_cout", s, a, b), m4.cout, ec);
          check($sformatf("w4_s%0d_a%0d_b%0d_ovf", s, a, b), m4.overflow, eo);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder/subtractor for the Computer Architecture Elements Catalog, and the sequential successor to the combinational catalog adder. It processes WIDTH-bit operands in CHUNK-bit slices, one slice per clock, and carries between slices through a register, so a narrow adder covers a wide datapath. A start/busy/done handshake lets the CPU datapath or a controller FSM issue an operation and wait for the result. It also adds subtract mode, carry-out and signed-overflow flags.

## Interface
- WIDTH, 32, operand and result width; must be a positive multiple of CHUNK.
- CHUNK, 8, slice width added per cycle; N = WIDTH/CHUNK cycles per operation.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while slices are being computed (RUN).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  raw carry out of the MSB (for sub, 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.

## Operation
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset: state goes to IDLE; busy, done, sum, cout and overflow are all 0. Latched operands and the slice index go to 0.
- States:
  - IDLE to RUN on start.
  - RUN to DONE after slice N−1.
  - DONE to RUN on start.
  - DONE to IDLE otherwise.
- Accepted start:
  - latch opA = a;
  - latch opB = sub ? ~b : b;
  - carry register = sub;
  - slice index i = 0;
  - clear sum.
- Each RUN cycle: sum[i*CHUNK +: CHUNK] gets the low CHUNK bits of opA slice + opB slice + carry. The carry register takes the slice carry-out, then i increments.
- Final slice:
  - cout = carry out of the MSB;
  - overflow = (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]).
  - Overflow uses effective operands, so subtract is handled correctly.
- start while in RUN is ignored; no queuing, and latched operands are unaffected.
- Changes on a, b or sub outside an accepted start have no effect.
- sum, cout and overflow keep their values after done until the next accepted start, which clears sum, cout and overflow.
- rst asserted mid-operation aborts immediately: IDLE, all outputs 0, and no done pulse.
- N = 1 (CHUNK == WIDTH) is legal: a single RUN cycle.

## Timing
- Start sampled at edge E0. busy is high for the cycles after E0 through EN−1 (N cycles).
- sum, cout and overflow are final and done = 1 in the cycle after EN. Latency from start edge to done is N+1 edges.
- done is high for exactly one cycle. busy and done are never high together.
- Back-to-back: start high during the DONE cycle is accepted at that edge; the next busy follows with no idle gap. Throughput is one result per N+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package adder_pkg:
  - state enum state_t {IDLE, RUN, DONE};
  - localparam-style helper for the index width, $clog2(N) with a minimum of 1.
- Sub-module adder_slice: combinational CHUNK-wide full adder with ports a, b, cin, s, cout. Instantiated once in multicycle_adder.
- Elaboration check: fatal error if WIDTH % CHUNK != 0.

## Test plan
All cases use WIDTH=32, CHUNK=8 unless stated.
- Wrap to zero: a=0xFFFFFFFF, b=1, sub=0, start → busy for 4 cycles, then done. sum=0x00000000, cout=1, overflow=0.
- Signed overflow on add: a=0x7FFFFFFF, b=1, sub=0 → sum=0x80000000, cout=0, overflow=1.
- Subtract with borrow: a=5, b=7, sub=1 → sum=0xFFFFFFFE, cout=0, overflow=0.
- Subtract overflow, then reset mid-operation:
  - a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, cout=1, overflow=1.
  - Then start a new operation and assert rst on its second RUN cycle → next cycle busy=0, done=0, sum=0, and no done pulse follows.
- Start ignored while busy:
  - Start a=1, b=2, then pulse start with a=100, b=100 during RUN → single done, sum=3.
  - Then start in the DONE cycle with a=10, b=20 → busy next cycle, done 4 cycles later, sum=30.
- Degenerate and narrow configurations:
  - WIDTH=8, CHUNK=8: a=0x80, b=0x80 → done after 1 RUN cycle, sum=0x00, cout=1, overflow=1.
  - WIDTH=4, CHUNK=1: exhaustive 4-bit add and sub checked against a reference model.
